// File: rtl/seg_scan.sv
// seg_scan: eight-digit multiplexed seven-segment scanner.
// Double-buffered input commits only at frame boundaries, with a per-digit blink.
module seg_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [7:0]  in_mask,
    input  logic [7:0]  in_blink,
    input  logic [7:0]  in_dp,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    logic [15:0] pre;
    logic [2:0]  idx;
    logic [7:0]  fcnt;
    logic        phase;
    logic [31:0] pend_data, disp_data;
    logic [7:0]  pend_mask, pend_blink, pend_dp;
    logic [7:0]  disp_mask, disp_blink, disp_dp;
    logic        pend_full;
    logic        tick, frame_end, fwrap, xfer, blank;
    logic [3:0]  nib;
    logic [6:0]  seg_d;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'h01;
            4'h1: decode = 7'h4F;
            4'h2: decode = 7'h12;
            4'h3: decode = 7'h06;
            4'h4: decode = 7'h4C;
            4'h5: decode = 7'h24;
            4'h6: decode = 7'h20;
            4'h7: decode = 7'h0F;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h04;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h60;
            4'hC: decode = 7'h31;
            4'hD: decode = 7'h42;
            4'hE: decode = 7'h30;
            default: decode = 7'h38;
        endcase
    endfunction

    assign tick      = pre == 16'(SCAN_DIV - 1);
    assign frame_end = tick && idx == 3'd7;
    assign fwrap     = fcnt == 8'(BLINK_FRAMES - 1);
    assign in_ready  = ~pend_full;
    assign xfer      = in_valid & in_ready;
    assign nib       = disp_data[{idx, 2'b00} +: 4];
    assign blank     = ~disp_mask[idx] | (disp_blink[idx] & ~phase);
    assign seg_d     = decode(nib);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre   <= '0;
            idx   <= '0;
            fcnt  <= '0;
            phase <= 1'b1;
        end else begin
            pre <= tick ? '0 : pre + 16'd1;
            if (tick)
                idx <= idx + 3'd1;
            if (frame_end) begin
                fcnt <= fwrap ? '0 : fcnt + 8'd1;
                if (fwrap)
                    phase <= ~phase;
            end
        end
    end

    // A word accepted on a boundary edge lands in pending only, so it waits a full frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_data  <= '0;
            pend_mask  <= '0;
            pend_blink <= '0;
            pend_dp    <= '0;
            pend_full  <= 1'b0;
            disp_data  <= '0;
            disp_mask  <= '0;
            disp_blink <= '0;
            disp_dp    <= '0;
        end else begin
            if (xfer) begin
                pend_data  <= in_data;
                pend_mask  <= in_mask;
                pend_blink <= in_blink;
                pend_dp    <= in_dp;
            end
            if (frame_end && pend_full) begin
                disp_data  <= pend_data;
                disp_mask  <= pend_mask;
                disp_blink <= pend_blink;
                disp_dp    <= pend_dp;
            end
            pend_full <= xfer | (pend_full & ~frame_end);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= blank ? 8'hFF : ~(8'd1 << idx);
            seg <= blank ? 7'h7F : seg_d;
            dp  <= blank | ~disp_dp[idx];
        end
    end
endmodule
